// File: rtl/mcp_mem_arbiter_if.sv
// Signal bundle between the multicycle CPU, the external loader/debug port
// and the shared unified memory; the arbiter uses the slave view.
interface mcp_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
);
  // CPU requester
  logic              cpu_req;
  logic              cpu_we;
  logic              cpu_isel;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;
  logic              cpu_stall;

  // External loader/debug requester
  logic              ext_req;
  logic              ext_we;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_wdata;
  logic [DATA_W-1:0] ext_rdata;
  logic              ext_ack;

  // Memory side and status
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              owner;
  logic              busy;

  modport slave (
    input  cpu_req, cpu_we, cpu_isel, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack, cpu_stall,
    input  ext_req, ext_we, ext_addr, ext_wdata,
    output ext_rdata, ext_ack,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output owner, busy
  );

  modport master (
    output cpu_req, cpu_we, cpu_isel, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack, cpu_stall,
    output ext_req, ext_we, ext_addr, ext_wdata,
    input  ext_rdata, ext_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  owner, busy
  );
endinterface

// File: rtl/mcp_mem_arbiter.sv
// Round-robin sequencer sharing the single-port unified memory between the
// CPU control FSM and an external loader, with fixed multi-cycle latency.
module mcp_mem_arbiter #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned WAIT_CYC  = 2,
  parameter int unsigned DM_OFFSET = 50
) (
  input  logic                CLK,
  input  logic                RST,
  mcp_mem_arbiter_if.slave    bus
);

  if ((WAIT_CYC < 1) || (WAIT_CYC > 7)) begin : g_bad_wait_cyc
    $error("mcp_mem_arbiter: WAIT_CYC must be in 1..7");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  localparam logic [2:0]        CNT_LOAD = 3'(WAIT_CYC - 1);
  localparam logic [ADDR_W-1:0] DM_OFF   = ADDR_W'(DM_OFFSET);

  state_t            state;
  state_t            state_nxt;
  logic [2:0]        cnt;
  logic              owner_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] ext_rdata_q;

  logic              grant_vld;
  logic              grant_ext;
  logic [ADDR_W-1:0] cpu_addr_eff;

  // Arbitration: a lone request wins; a tie goes to whoever did not own last.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    grant_vld    = bus.cpu_req | bus.ext_req;
    grant_ext    = bus.ext_req;
    cpu_addr_eff = bus.cpu_isel ? (bus.cpu_addr + DM_OFF) : bus.cpu_addr;
    if (bus.cpu_req && bus.ext_req) begin
      grant_ext = ~owner_q;
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (grant_vld) state_nxt = ACCESS;
      ACCESS:  if (cnt == 3'd0) state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant latching, latency counter and read-data capture.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt         <= '0;
      owner_q     <= 1'b1;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      ext_rdata_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant_vld) begin
            owner_q <= grant_ext;
            cnt     <= CNT_LOAD;
            if (grant_ext) begin
              we_q    <= bus.ext_we;
              addr_q  <= bus.ext_addr;
              wdata_q <= bus.ext_wdata;
            end else begin
              we_q    <= bus.cpu_we;
              addr_q  <= cpu_addr_eff;
              wdata_q <= bus.cpu_wdata;
            end
          end
        end
        ACCESS: begin
          if (cnt == 3'd0) begin
            if (!we_q) begin
              if (owner_q) ext_rdata_q <= bus.mem_rdata;
              else         cpu_rdata_q <= bus.mem_rdata;
            end
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs: decoded from state so an aborted access drops mem_en/mem_we at once.
  always_comb begin
    bus.mem_en    = (state == ACCESS);
    bus.mem_we    = (state == ACCESS) && we_q && (cnt == CNT_LOAD);
    bus.mem_addr  = addr_q;
    bus.mem_wdata = wdata_q;
    bus.cpu_ack   = (state == ACK) && !owner_q;
    bus.ext_ack   = (state == ACK) &&  owner_q;
    bus.cpu_rdata = cpu_rdata_q;
    bus.ext_rdata = ext_rdata_q;
    bus.owner     = owner_q;
    bus.busy      = (state != IDLE);
    bus.cpu_stall = bus.cpu_req & ~bus.cpu_ack;
  end

endmodule

// File: tb/tb_mcp_mem_arbiter.sv
// Directed bench for mcp_mem_arbiter with WAIT_CYC=2 and a small memory model;
// inputs change and outputs are sampled on the falling clock edge.
module tb_mcp_mem_arbiter;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;

  logic CLK;
  logic RST;
  int   n_checks;
  int   n_errors;

  logic [DATA_W-1:0] mem [256];

  mcp_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mcp_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_CYC(2), .DM_OFFSET(50)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Memory model: combinational read, write on the strobe, preload while in reset.
  assign bus.mem_rdata = mem[bus.mem_addr];
  always @(posedge CLK) begin
    if (RST) begin
      mem[8'h05] <= 32'hDEADBEEF;
      mem[8'h42] <= 32'hA5A50042;
      mem[8'h22] <= 32'h5A5A0022;
      mem[8'h80] <= 32'h00000000;
    end else if (bus.mem_en && bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  // Wait for the selected ack, bounded; lat counts falling edges until it shows.
  task automatic wait_ack(input bit ext, output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!(ext ? bus.ext_ack : bus.cpu_ack) && lat < 20);
    if (!(ext ? bus.ext_ack : bus.cpu_ack)) check("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    bus.cpu_req = 1'b0;
    bus.ext_req = 1'b0;
    tick();
    tick();
    RST = 1'b0;
  endtask

  initial begin
    int lat;
    int acks;
    bit exp_ext;
    n_checks      = 0;
    n_errors      = 0;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_isel  = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.ext_req   = 1'b0;
    bus.ext_we    = 1'b0;
    bus.ext_addr  = '0;
    bus.ext_wdata = '0;
    do_reset();

    // Reset values
    check("rst_owner",     32'(bus.owner),     32'd1);
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_mem_en",    32'(bus.mem_en),    32'd0);
    check("rst_mem_we",    32'(bus.mem_we),    32'd0);
    check("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
    check("rst_mem_wdata", bus.mem_wdata,      32'd0);
    check("rst_cpu_ack",   32'(bus.cpu_ack),   32'd0);
    check("rst_ext_ack",   32'(bus.ext_ack),   32'd0);
    check("rst_cpu_rdata", bus.cpu_rdata,      32'd0);
    check("rst_ext_rdata", bus.ext_rdata,      32'd0);

    // 1: CPU instruction read of 0x05, cycle by cycle
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_isel = 1'b0; bus.cpu_addr = 8'h05;
    #1 check("t1_stall_t", 32'(bus.cpu_stall), 32'd1);
    tick();
    check("t1_en_t1",    32'(bus.mem_en),    32'd1);
    check("t1_we_t1",    32'(bus.mem_we),    32'd0);
    check("t1_addr_t1",  32'(bus.mem_addr),  32'h05);
    check("t1_busy_t1",  32'(bus.busy),      32'd1);
    check("t1_stall_t1", 32'(bus.cpu_stall), 32'd1);
    tick();
    check("t1_en_t2",    32'(bus.mem_en),    32'd1);
    check("t1_ack_t2",   32'(bus.cpu_ack),   32'd0);
    check("t1_stall_t2", 32'(bus.cpu_stall), 32'd1);
    tick();
    check("t1_ack_t3",   32'(bus.cpu_ack),   32'd1);
    check("t1_en_t3",    32'(bus.mem_en),    32'd0);
    check("t1_busy_t3",  32'(bus.busy),      32'd1);
    check("t1_rdata",    bus.cpu_rdata,      32'hDEADBEEF);
    check("t1_stall_t3", 32'(bus.cpu_stall), 32'd0);
    check("t1_owner",    32'(bus.owner),     32'd0);
    bus.cpu_req = 1'b0;
    tick();
    check("t1_ack_t4",   32'(bus.cpu_ack),   32'd0);
    check("t1_busy_t4",  32'(bus.busy),      32'd0);

    // 2: CPU data reads with offset, including address wrap
    bus.cpu_req = 1'b1; bus.cpu_isel = 1'b1; bus.cpu_addr = 8'h10;
    tick();
    check("t2_addr_off", 32'(bus.mem_addr), 32'h42);
    wait_ack(1'b0, lat);
    check("t2_lat_off",   32'(lat + 1),  32'd3);
    check("t2_rdata_off", bus.cpu_rdata, 32'hA5A50042);
    bus.cpu_req = 1'b0;
    tick();
    bus.cpu_req = 1'b1; bus.cpu_addr = 8'hF0;
    tick();
    check("t2_addr_wrap", 32'(bus.mem_addr), 32'h22);
    wait_ack(1'b0, lat);
    check("t2_rdata_wrap", bus.cpu_rdata, 32'h5A5A0022);
    bus.cpu_req = 1'b0;
    bus.cpu_isel = 1'b0;
    tick();

    // 3: simultaneous requests after reset alternate CPU, ext, CPU, ext
    do_reset();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_isel = 1'b0; bus.cpu_addr = 8'h05;
    bus.ext_req = 1'b1; bus.ext_we = 1'b0; bus.ext_addr = 8'h22;
    for (int i = 0; i < 4; i++) begin
      exp_ext = (i % 2) == 1;
      acks = 0;
      do begin
        tick();
        acks++;
      end while (!(bus.cpu_ack || bus.ext_ack) && acks < 20);
      check($sformatf("t3_lat_%0d", i),   32'(acks),        32'd4 - ((i == 0) ? 32'd1 : 32'd0));
      check($sformatf("t3_ext_%0d", i),   32'(bus.ext_ack), 32'(exp_ext));
      check($sformatf("t3_cpu_%0d", i),   32'(bus.cpu_ack), 32'(!exp_ext));
      check($sformatf("t3_own_%0d", i),   32'(bus.owner),   32'(exp_ext));
      check($sformatf("t3_stall_%0d", i), 32'(bus.cpu_stall), 32'(exp_ext));
    end
    check("t3_ext_rdata", bus.ext_rdata, 32'h5A5A0022);
    check("t3_cpu_rdata", bus.cpu_rdata, 32'hDEADBEEF);
    bus.cpu_req = 1'b0;
    bus.ext_req = 1'b0;
    tick();

    // 4: external write while the CPU waits for a read
    bus.ext_req = 1'b1; bus.ext_we = 1'b1; bus.ext_addr = 8'h80; bus.ext_wdata = 32'h12345678;
    tick();
    check("t4_we_c1",    32'(bus.mem_we),   32'd1);
    check("t4_wdata",    bus.mem_wdata,     32'h12345678);
    check("t4_addr",     32'(bus.mem_addr), 32'h80);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_isel = 1'b0; bus.cpu_addr = 8'h05;
    #1 check("t4_stall_c1", 32'(bus.cpu_stall), 32'd1);
    tick();
    check("t4_we_c2",    32'(bus.mem_we),    32'd0);
    check("t4_en_c2",    32'(bus.mem_en),    32'd1);
    check("t4_stall_c2", 32'(bus.cpu_stall), 32'd1);
    tick();
    check("t4_ext_ack",  32'(bus.ext_ack),   32'd1);
    check("t4_stall_c3", 32'(bus.cpu_stall), 32'd1);
    check("t4_ext_rd_kept", bus.ext_rdata,   32'h5A5A0022);
    bus.ext_req = 1'b0;
    wait_ack(1'b0, lat);
    check("t4_cpu_lat",  32'(lat),           32'd4);
    check("t4_cpu_rd",   bus.cpu_rdata,      32'hDEADBEEF);
    check("t4_stall_ack", 32'(bus.cpu_stall), 32'd0);
    bus.cpu_req = 1'b0;
    tick();
    bus.ext_req = 1'b1; bus.ext_we = 1'b0; bus.ext_addr = 8'h80;
    wait_ack(1'b1, lat);
    check("t4_readback", bus.ext_rdata, 32'h12345678);
    bus.ext_req = 1'b0;
    tick();

    // 5: reset during the second ACCESS cycle of a CPU read aborts it
    bus.cpu_req = 1'b1; bus.cpu_addr = 8'h05;
    tick();
    tick();
    check("t5_en_pre", 32'(bus.mem_en), 32'd1);
    RST = 1'b1;
    bus.cpu_req = 1'b0;
    tick();
    check("t5_ack",       32'(bus.cpu_ack),  32'd0);
    check("t5_en",        32'(bus.mem_en),   32'd0);
    check("t5_owner",     32'(bus.owner),    32'd1);
    check("t5_busy",      32'(bus.busy),     32'd0);
    check("t5_cpu_rdata", bus.cpu_rdata,     32'd0);
    check("t5_ext_rdata", bus.ext_rdata,     32'd0);
    check("t5_mem_addr",  32'(bus.mem_addr), 32'd0);
    RST = 1'b0;
    tick();
    check("t5_ack_after", 32'(bus.cpu_ack), 32'd0);

    // 6: cpu_addr changes mid-access do not reach the memory
    bus.cpu_req = 1'b1; bus.cpu_addr = 8'h05; bus.cpu_isel = 1'b0;
    tick();
    check("t6_addr_c1", 32'(bus.mem_addr), 32'h05);
    bus.cpu_addr = 8'h22; bus.cpu_isel = 1'b1;
    tick();
    check("t6_addr_c2", 32'(bus.mem_addr), 32'h05);
    tick();
    check("t6_ack",     32'(bus.cpu_ack),  32'd1);
    check("t6_addr_c3", 32'(bus.mem_addr), 32'h05);
    check("t6_rdata",   bus.cpu_rdata,     32'hDEADBEEF);
    bus.cpu_req = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
